// File: rtl/sdm_counter_pkg.sv
// ============================================================================
// Module   : sdm_counter_pkg
// Brief    : Shared constants and helpers for the SDM counter family.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sdm_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module   : tick_prescaler
// Brief    : Enable-gated divider producing one tick per PRESCALE enabled cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tick_prescaler
    import sdm_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            logic unused_inputs;
            assign unused_inputs = ^{clk, reset, restart};
            assign tick          = en;
        end else begin : g_divide
            localparam int              PW   = clog2(PRESCALE);
            localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);
            localparam logic [PW-1:0]   ONE  = PW'(1);

            logic [PW-1:0] phase_q;
            logic [PW-1:0] phase_d;
            logic          tick_w;

            assign tick_w = en && (phase_q == LAST);
            assign tick   = tick_w;

            always_comb begin
                phase_d = phase_q;
                if (restart) begin
                    phase_d = '0;
                end else if (tick_w) begin
                    phase_d = '0;
                end else if (en) begin
                    phase_d = phase_q + ONE;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    phase_q <= '0;
                end else begin
                    phase_q <= phase_d;
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/updown_mod_counter.sv
// ============================================================================
// Module   : updown_mod_counter
// Brief    : Up/down modulo-(MAX_VAL+1) counter with clear, load, prescaler
//            and wrap or saturate handling at the range limits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module updown_mod_counter
    import sdm_counter_pkg::*;
#(
    parameter int WIDTH    = 7,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int PRESCALE = 1,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam bit               SAT_EN = (SATURATE != MODE_WRAP);

    generate
        if ((longint'(MAX_VAL) > (longint'(1) << WIDTH) - 1) || (MAX_VAL < 1)) begin : g_bad_max_val
            $error("updown_mod_counter: MAX_VAL must lie in 1..2**WIDTH-1");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("updown_mod_counter: PRESCALE must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             tick;
    logic             restart;

    assign restart = clr | load;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MAX_Q) ? MAX_Q : load_val;
        end else if (tick) begin
            if (up_dn == DIR_UP) begin
                if (count_q == MAX_Q) begin
                    ovf_d = 1'b1;
                    if (!SAT_EN) begin
                        count_d = '0;
                    end
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (count_q == '0) begin
                    ovf_d = 1'b1;
                    if (!SAT_EN) begin
                        count_d = MAX_Q;
                    end
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign q   = count_q;
    assign ovf = ovf_q;
    assign tc  = (up_dn == DIR_UP) ? (count_q == MAX_Q) : (count_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
// ============================================================================
// Module   : tb_updown_mod_counter
// Brief    : Directed checks for wrap, saturate and prescaled counter variants.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_updown_mod_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       clr;
    logic       load;
    logic [6:0] load_val;

    logic [6:0] q_w, q_s, q_p;
    logic       tc_w, tc_s, tc_p;
    logic       ovf_w, ovf_s, ovf_p;

    int checks;
    int failures;

    updown_mod_counter #(.WIDTH(7), .MAX_VAL(99), .PRESCALE(1), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .q(q_w), .tc(tc_w), .ovf(ovf_w)
    );

    updown_mod_counter #(.WIDTH(7), .MAX_VAL(99), .PRESCALE(1), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .q(q_s), .tc(tc_s), .ovf(ovf_s)
    );

    updown_mod_counter #(.WIDTH(7), .MAX_VAL(99), .PRESCALE(4), .SATURATE(0)) dut_ps (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .q(q_p), .tc(tc_p), .ovf(ovf_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        en       = 1'b0;
        up_dn    = 1'b1;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (q_w !== 7'd0)  begin failures++; $display("FAIL reset_q_wrap got=%0d exp=0", q_w); end
        checks++; if (q_s !== 7'd0)  begin failures++; $display("FAIL reset_q_sat got=%0d exp=0", q_s); end
        checks++; if (q_p !== 7'd0)  begin failures++; $display("FAIL reset_q_ps got=%0d exp=0", q_p); end
        checks++; if (ovf_w !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf_w); end
        checks++; if (tc_w !== 1'b0) begin failures++; $display("FAIL reset_tc_up got=%b exp=0", tc_w); end
    endtask

    task automatic test_wrap_up();
        int exp_q;
        do_reset();
        en    = 1'b1;
        up_dn = 1'b1;
        exp_q = 0;
        for (int i = 1; i <= 101; i++) begin
            edge_step();
            exp_q = (exp_q + 1) % 100;
            checks++;
            if (q_w !== 7'(exp_q)) begin
                failures++; $display("FAIL wrap_up_q step=%0d got=%0d exp=%0d", i, q_w, exp_q);
            end
            checks++;
            if (tc_w !== (exp_q == 99)) begin
                failures++; $display("FAIL wrap_up_tc step=%0d got=%b exp=%b", i, tc_w, (exp_q == 99));
            end
            checks++;
            if (ovf_w !== (i == 100)) begin
                failures++; $display("FAIL wrap_up_ovf step=%0d got=%b exp=%b", i, ovf_w, (i == 100));
            end
        end
    endtask

    task automatic test_wrap_down();
        do_reset();
        en    = 1'b1;
        up_dn = 1'b0;
        #1;
        checks++; if (tc_w !== 1'b1) begin failures++; $display("FAIL down_tc_at_zero got=%b exp=1", tc_w); end
        edge_step();
        checks++; if (q_w !== 7'd99) begin failures++; $display("FAIL down_first_q got=%0d exp=99", q_w); end
        checks++; if (ovf_w !== 1'b1) begin failures++; $display("FAIL down_first_ovf got=%b exp=1", ovf_w); end
        checks++; if (tc_w !== 1'b0) begin failures++; $display("FAIL down_tc_at_99 got=%b exp=0", tc_w); end
        edge_step();
        checks++; if (q_w !== 7'd98) begin failures++; $display("FAIL down_second_q got=%0d exp=98", q_w); end
        checks++; if (ovf_w !== 1'b0) begin failures++; $display("FAIL down_second_ovf got=%b exp=0", ovf_w); end
        checks++; if (q_s !== 7'd0) begin failures++; $display("FAIL sat_down_hold_q got=%0d exp=0", q_s); end
        checks++; if (ovf_s !== 1'b1) begin failures++; $display("FAIL sat_down_hold_ovf got=%b exp=1", ovf_s); end
    endtask

    task automatic test_saturate();
        logic [6:0] exp_q   [5] = '{7'd97, 7'd98, 7'd99, 7'd99, 7'd99};
        logic       exp_ovf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        en       = 1'b1;
        up_dn    = 1'b1;
        load_val = 7'd97;
        load     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            edge_step();
            load = 1'b0;
            checks++;
            if (q_s !== exp_q[i]) begin
                failures++; $display("FAIL sat_q idx=%0d got=%0d exp=%0d", i, q_s, exp_q[i]);
            end
            checks++;
            if (ovf_s !== exp_ovf[i]) begin
                failures++; $display("FAIL sat_ovf idx=%0d got=%b exp=%b", i, ovf_s, exp_ovf[i]);
            end
        end
        checks++; if (tc_s !== 1'b1) begin failures++; $display("FAIL sat_tc got=%b exp=1", tc_s); end
        en = 1'b0;
        edge_step();
        checks++; if (q_s !== 7'd99) begin failures++; $display("FAIL sat_idle_q got=%0d exp=99", q_s); end
        checks++; if (ovf_s !== 1'b0) begin failures++; $display("FAIL sat_idle_ovf got=%b exp=0", ovf_s); end
    endtask

    task automatic test_prescale();
        logic [6:0] exp_run [6] = '{7'd0, 7'd0, 7'd0, 7'd1, 7'd1, 7'd1};
        do_reset();
        en    = 1'b1;
        up_dn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            edge_step();
            checks++;
            if (q_p !== exp_run[i]) begin
                failures++; $display("FAIL ps_run edge=%0d got=%0d exp=%0d", i + 1, q_p, exp_run[i]);
            end
        end
        en = 1'b0;
        repeat (3) edge_step();
        checks++; if (q_p !== 7'd1) begin failures++; $display("FAIL ps_paused_q got=%0d exp=1", q_p); end
        en = 1'b1;
        edge_step();
        checks++; if (q_p !== 7'd1) begin failures++; $display("FAIL ps_resume1_q got=%0d exp=1", q_p); end
        edge_step();
        checks++; if (q_p !== 7'd2) begin failures++; $display("FAIL ps_resume2_q got=%0d exp=2", q_p); end
        edge_step();
        load_val = 7'd10;
        load     = 1'b1;
        edge_step();
        load = 1'b0;
        checks++; if (q_p !== 7'd10) begin failures++; $display("FAIL ps_load_q got=%0d exp=10", q_p); end
        repeat (3) edge_step();
        checks++; if (q_p !== 7'd10) begin failures++; $display("FAIL ps_after_load3_q got=%0d exp=10", q_p); end
        edge_step();
        checks++; if (q_p !== 7'd11) begin failures++; $display("FAIL ps_after_load4_q got=%0d exp=11", q_p); end
    endtask

    task automatic test_priority();
        do_reset();
        load_val = 7'd30;
        load     = 1'b1;
        edge_step();
        checks++; if (q_w !== 7'd30) begin failures++; $display("FAIL prio_preload got=%0d exp=30", q_w); end
        en       = 1'b1;
        clr      = 1'b1;
        load_val = 7'd50;
        edge_step();
        checks++; if (q_w !== 7'd0) begin failures++; $display("FAIL prio_clr_over_load got=%0d exp=0", q_w); end
        clr      = 1'b0;
        load_val = 7'd120;
        edge_step();
        checks++; if (q_w !== 7'd99) begin failures++; $display("FAIL prio_load_clamp got=%0d exp=99", q_w); end
        checks++; if (ovf_w !== 1'b0) begin failures++; $display("FAIL prio_load_ovf got=%b exp=0", ovf_w); end
        load_val = 7'd99;
        edge_step();
        load = 1'b0;
        checks++; if (q_s !== 7'd99) begin failures++; $display("FAIL prio_load_exact got=%0d exp=99", q_s); end
        en  = 1'b0;
        clr = 1'b1;
        edge_step();
        clr = 1'b0;
        checks++; if (q_w !== 7'd0) begin failures++; $display("FAIL prio_clr_no_en got=%0d exp=0", q_w); end
    endtask

    task automatic test_async_reset();
        do_reset();
        load_val = 7'd99;
        load     = 1'b1;
        edge_step();
        load  = 1'b0;
        en    = 1'b1;
        up_dn = 1'b1;
        edge_step();
        checks++; if (ovf_w !== 1'b1) begin failures++; $display("FAIL ar_setup_ovf got=%b exp=1", ovf_w); end
        #2 reset = 1'b1;
        #1;
        checks++; if (ovf_w !== 1'b0) begin failures++; $display("FAIL ar_ovf_wrap got=%b exp=0", ovf_w); end
        checks++; if (q_s !== 7'd0) begin failures++; $display("FAIL ar_q_sat got=%0d exp=0", q_s); end
        checks++; if (ovf_s !== 1'b0) begin failures++; $display("FAIL ar_ovf_sat got=%b exp=0", ovf_s); end
        #2 reset = 1'b0;
        en       = 1'b0;
        load_val = 7'd42;
        load     = 1'b1;
        edge_step();
        load = 1'b0;
        en   = 1'b1;
        repeat (2) edge_step();
        checks++; if (q_p !== 7'd42) begin failures++; $display("FAIL ar_ps_setup got=%0d exp=42", q_p); end
        #2 reset = 1'b1;
        #1;
        checks++; if (q_p !== 7'd0) begin failures++; $display("FAIL ar_q_ps got=%0d exp=0", q_p); end
        #2 reset = 1'b0;
        repeat (3) edge_step();
        checks++; if (q_p !== 7'd0) begin failures++; $display("FAIL ar_ps_resume3 got=%0d exp=0", q_p); end
        edge_step();
        checks++; if (q_p !== 7'd1) begin failures++; $display("FAIL ar_ps_resume4 got=%0d exp=1", q_p); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_prescale();
        test_priority();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
